// File: rtl/uart_buffer_seq.sv
// Sequencer between the RS-232 receiver/transmitter and the external RX/TX frame buffers.
// Collects received bytes into RX frames, then streams the filled TX frame out byte by byte.
module uart_buffer_seq #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 11,
  parameter int FRAME_LEN = 1250,
  parameter int TIMEOUT   = 50000
) (
  input  logic              genclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rbr,
  input  logic              rdrdy,
  output logic              rdrst,
  input  logic              rx_full,
  input  logic              rx_empty,
  input  logic              rfd_rx,
  input  logic              ack_rx,
  output logic              newdata,
  output logic [DATA_W-1:0] rx_buf,
  input  logic              tx_full,
  input  logic              tx_empty,
  input  logic              dav_tx,
  input  logic              ack_txbuf,
  input  logic [DATA_W-1:0] txbuf,
  output logic              rfd_tx,
  output logic              ack_tx,
  input  logic              tbre,
  output logic [DATA_W-1:0] tdin,
  output logic              wrn,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  tx_count,
  output logic              overrun,
  output logic [3:0]        state_dbg
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RX_ARM    = 4'd1;
  localparam logic [3:0] S_RX_WAIT   = 4'd2;
  localparam logic [3:0] S_RX_PUSH   = 4'd3;
  localparam logic [3:0] S_RX_ACK    = 4'd4;
  localparam logic [3:0] S_DRAIN     = 4'd5;
  localparam logic [3:0] S_TX_FILL   = 4'd6;
  localparam logic [3:0] S_TX_IDLE   = 4'd7;
  localparam logic [3:0] S_TX_REQ    = 4'd8;
  localparam logic [3:0] S_TX_ACK    = 4'd9;
  localparam logic [3:0] S_TX_STROBE = 4'd10;
  localparam logic [3:0] S_TX_WAIT   = 4'd11;

  localparam int               IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_LEN);

  logic [3:0]        state_reg;
  logic [3:0]        state_next;
  logic [IDLE_W-1:0] idle_reg;
  logic [CNT_W-1:0]  rx_count_reg;
  logic [CNT_W-1:0]  tx_count_reg;
  logic [DATA_W-1:0] rx_buf_reg;
  logic [DATA_W-1:0] tdin_reg;
  logic              rdrst_reg;
  logic              newdata_reg;
  logic              rfd_tx_reg;
  logic              ack_tx_reg;
  logic              wrn_reg;
  logic              overrun_reg;

  logic [CNT_W-1:0]  rx_count_inc;
  logic              frame_done;
  logic              timeout_hit;
  logic              rx_phase;

  // Saturate at FRAME_LEN when frame length closing is enabled, otherwise wrap.
  assign rx_count_inc = ((FRAME_LEN != 0) && (rx_count_reg == FRAME_CNT))
                        ? rx_count_reg : rx_count_reg + CNT_W'(1);
  assign frame_done   = (FRAME_LEN != 0) && (rx_count_inc == FRAME_CNT);
  assign timeout_hit  = (TIMEOUT != 0) && (rx_count_reg != '0) && (idle_reg == IDLE_LAST);
  assign rx_phase     = (state_reg <= S_RX_ACK);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      state_next = S_RX_ARM;
      S_RX_ARM:    if (!rdrdy) state_next = S_RX_WAIT;
      S_RX_WAIT: begin
        if (rdrdy)            state_next = S_RX_PUSH;
        else if (timeout_hit) state_next = S_DRAIN;
      end
      S_RX_PUSH: begin
        if (rx_full)     state_next = S_DRAIN;
        else if (rfd_rx) state_next = S_RX_ACK;
      end
      S_RX_ACK:    if (ack_rx) state_next = (frame_done || rx_full) ? S_DRAIN : S_IDLE;
      S_DRAIN:     if (rx_empty) state_next = S_TX_FILL;
      S_TX_FILL:   if (tx_full) state_next = S_TX_IDLE;
      S_TX_IDLE:   if (tbre) state_next = S_TX_REQ;
      S_TX_REQ: begin
        if (dav_tx)        state_next = S_TX_ACK;
        else if (tx_empty) state_next = S_IDLE;
      end
      S_TX_ACK:    if (ack_txbuf) state_next = S_TX_STROBE;
      S_TX_STROBE: state_next = S_TX_WAIT;
      S_TX_WAIT:   if (!tbre) state_next = S_TX_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge genclk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      idle_reg     <= '0;
      rx_count_reg <= '0;
      tx_count_reg <= '0;
      rx_buf_reg   <= '0;
      tdin_reg     <= '0;
      rdrst_reg    <= 1'b1;
      newdata_reg  <= 1'b0;
      rfd_tx_reg   <= 1'b0;
      ack_tx_reg   <= 1'b0;
      wrn_reg      <= 1'b1;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Handshake outputs are level signals tied to the state being entered.
      rdrst_reg   <= (state_next == S_IDLE);
      newdata_reg <= (state_next == S_RX_ACK);
      rfd_tx_reg  <= (state_next == S_TX_REQ);
      ack_tx_reg  <= (state_next == S_TX_ACK);
      wrn_reg     <= (state_next != S_TX_STROBE);

      if (state_reg == S_RX_WAIT && rdrdy) rx_buf_reg <= rbr;
      if (state_reg == S_RX_ACK && ack_rx) rx_count_reg <= rx_count_inc;
      if (state_reg == S_RX_PUSH && rx_full) overrun_reg <= 1'b1;
      if (state_reg == S_DRAIN && rx_empty) begin
        rx_count_reg <= '0;
        tx_count_reg <= '0;
      end
      if (state_reg == S_TX_REQ && dav_tx) tdin_reg <= txbuf;
      if (state_reg == S_TX_STROBE) tx_count_reg <= tx_count_reg + CNT_W'(1);

      // Idle time runs across the whole receive phase so a frame closes a fixed
      // number of cycles after the last capture, regardless of handshake length.
      if (state_reg == S_RX_WAIT && rdrdy)
        idle_reg <= '0;
      else if (!rx_phase)
        idle_reg <= '0;
      else if (rx_count_reg != '0 && idle_reg != IDLE_LAST)
        idle_reg <= idle_reg + IDLE_W'(1);
    end
  end

  assign rdrst     = rdrst_reg;
  assign newdata   = newdata_reg;
  assign rx_buf    = rx_buf_reg;
  assign rfd_tx    = rfd_tx_reg;
  assign ack_tx    = ack_tx_reg;
  assign tdin      = tdin_reg;
  assign wrn       = wrn_reg;
  assign rx_count  = rx_count_reg;
  assign tx_count  = tx_count_reg;
  assign overrun   = overrun_reg;
  assign state_dbg = state_reg;

endmodule

// File: doc/uart_buffer_seq.md
Name: uart_buffer_seq

Overview:
- Parametrised sequencer between the RS-232 receiver/transmitter and the external RX and TX frame buffers.
- Receive phase: collects UART bytes into the RX buffer until a frame closes. A frame closes on RX full, on FRAME_LEN bytes, or on an idle timeout.
- Transmit phase: waits for the TX buffer to fill, then streams it byte by byte to the UART transmitter. Returns to receive when the TX buffer is empty.
- Reports byte counts, a sticky overrun flag and a state code for LEDs and debug.

Parameters:
- DATA_W, 8, UART/buffer data width.
- CNT_W, 11, width of byte counters and of FRAME_LEN.
- FRAME_LEN, 1250, bytes per frame that force the switch to transmit; 0 disables this condition.
- TIMEOUT, 50000, idle genclk cycles after the last received byte that close a partial frame; 0 disables.

Ports:
- genclk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rbr  in  DATA_W  received byte from UART receiver.
- rdrdy  in  1  level: receiver holds a byte.
- rdrst  out  1  clear receiver data-ready.
- rx_full  in  1  RX buffer full.
- rx_empty  in  1  RX buffer empty, i.e. the downstream consumer has drained it.
- rfd_rx  in  1  RX buffer ready for data.
- ack_rx  in  1  RX buffer accepted rx_buf.
- newdata  out  1  rx_buf valid.
- rx_buf  out  DATA_W  byte to RX buffer.
- tx_full  in  1  TX buffer full, frame ready.
- tx_empty  in  1  TX buffer empty.
- dav_tx  in  1  TX buffer presents txbuf.
- ack_txbuf  in  1  TX buffer saw ack_tx.
- txbuf  in  DATA_W  byte from TX buffer.
- rfd_tx  out  1  request next TX byte.
- ack_tx  out  1  TX byte taken.
- tbre  in  1  transmitter holding register empty.
- tdin  out  DATA_W  byte to transmitter.
- wrn  out  1  transmitter write strobe, active-low.
- rx_count  out  CNT_W  bytes accepted in current frame.
- tx_count  out  CNT_W  bytes sent in current frame.
- overrun  out  1  sticky: byte dropped because RX was full.
- state_dbg  out  4  current state code.

Behaviour:
- Single clock domain: state and every output registered on the rising edge of genclk.
- Reset values (rst high at any edge, including mid-transfer): state IDLE.
  - rdrst=1.
  - newdata, rfd_tx, ack_tx, overrun=0.
  - wrn=1.
  - rx_buf, tdin, rx_count, tx_count=0.
  - Idle counter=0.
- States and state_dbg codes:
  - IDLE(0): rdrst=1, newdata=0; next cycle -> RX_ARM.
  - RX_ARM(1): rdrst=0; when rdrdy=0 -> RX_WAIT.
  - RX_WAIT(2): wait for a byte or a frame close.
    - Idle counter increments each cycle while rx_count>0.
    - rdrdy=1: capture rx_buf<=rbr, clear idle counter, -> RX_PUSH. rdrdy has priority over timeout in the same cycle.
    - TIMEOUT!=0, rx_count>0 and idle counter==TIMEOUT-1: -> DRAIN.
  - RX_PUSH(3): decide whether the RX buffer can take the byte.
    - rx_full=1: byte discarded, overrun<=1, -> DRAIN.
    - Else if rfd_rx=1: newdata<=1, -> RX_ACK.
    - Else stay.
  - RX_ACK(4): hold newdata and rx_buf until ack_rx=1.
    - Then newdata<=0 and rx_count<=rx_count+1.
    - If FRAME_LEN!=0 and the new count==FRAME_LEN, or rx_full=1: -> DRAIN.
    - Otherwise -> IDLE, which pulses rdrst for 1 cycle.
  - DRAIN(5): when rx_empty=1: rx_count<=0, tx_count<=0, -> TX_FILL.
  - TX_FILL(6): when tx_full=1 -> TX_IDLE.
  - TX_IDLE(7): wrn=1, ack_tx=0; when tbre=1 -> TX_REQ.
  - TX_REQ(8): rfd_tx=1.
    - dav_tx=1: tdin<=txbuf, rfd_tx<=0, -> TX_ACK. dav_tx wins over tx_empty in the same cycle.
    - Else if tx_empty=1: rfd_tx<=0, -> IDLE.
  - TX_ACK(9): ack_tx=1; when ack_txbuf=1: ack_tx<=0, -> TX_STROBE.
  - TX_STROBE(10): write one byte to the transmitter.
    - wrn=0 for exactly one cycle, with tdin stable from TX_ACK onward.
    - tx_count<=tx_count+1 (wraps modulo 2^CNT_W); -> TX_WAIT.
  - TX_WAIT(11): wrn=1; when tbre=0, i.e. the transmitter has accepted the byte, -> TX_IDLE.
- Codes 12-15 are unused; they recover to IDLE next cycle.
- Counter wrap: rx_count saturates at FRAME_LEN when enabled, otherwise wraps.
- overrun clears only on rst.
- Latency: rdrdy rise to newdata=1 is 2 cycles if rfd_rx=1 and rx_full=0.

Test Plan:
- Reset mid-frame: rst in TX_ACK with ack_tx=1 -> next edge ack_tx=0, wrn=1, state_dbg=0, counts 0.
- Single byte: rbr=0xA5, rdrdy pulse, rfd_rx=1, ack_rx after 3 cycles -> rx_buf=0xA5, newdata high until ack, rx_count=1, rdrst 1-cycle pulse.
- Frame length: FRAME_LEN=4, send 4 bytes -> state_dbg=5 after 4th ack_rx; rx_count=0 once rx_empty.
- Timeout: TIMEOUT=16, 2 bytes then silence -> DRAIN exactly 16 cycles after last capture; rdrdy arriving on the expiry cycle instead -> RX_PUSH.
- Overrun: rx_full=1 when a byte arrives -> overrun=1, byte not presented (newdata stays 0), -> DRAIN.
- TX stream: tx_full, 3 bytes 0x11,0x22,0x33 via dav_tx, then tx_empty -> 3 single-cycle wrn lows with matching tdin, tx_count=3, return to IDLE.
